fp16_norm_pack: RTL and testbench
=================================

Name: fp16_norm_pack

Overview:
- Back end of the signed half-precision multiply path.
- The multiplier front end unpacks two FP16 operands and emits a raw sign, exponent sum and unnormalised mantissa product. This block takes that triple and produces a packed IEEE-754 binary16 word.
- Processing order: iterative normalisation, round-to-nearest-even, overflow to infinity, flush of underflow to signed zero.
- Valid/ready handshake on both sides.

Parameters:
- MANT_W, 22, width of the raw mantissa product. Value is in_mant * 2^-20, so a normal product lies in [1,4).
- EXP_W, 8, width of the internal signed exponent register. Sized so that no sequence of shifts can wrap it.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  raw product present
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  product sign
- in_exp  in  7  two's-complement biased exponent, ea+eb-15, range -15..45
- in_mant  in  MANT_W  raw mantissa product
- out_valid  out  1  packed result valid; held until accepted
- out_ready  in  1  downstream accepts
- out_data  out  16  packed FP16 result {sign, exp[4:0], frac[9:0]}

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, out_data=16'h0000.
  - Internal sign, exp and mant registers cleared.
  - Reset mid-operation abandons the job with no output.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register sign, sign-extend in_exp to EXP_W, register mant.
  - If in_mant==0, go to ROUND with a zero flag set; otherwise go to NORM.
- NORM: one action per cycle.
  - If mant[21]=1: mant>>=1, sticky-OR the shifted-out bit into mant[0], exp+=1, then go to ROUND.
  - Else if mant[20]=0: mant<<=1, exp-=1, stay in NORM. At most 20 left shifts, because mant is nonzero.
  - Else go to ROUND.
- ROUND: combinational RNE on the normalised mant, result registered.
  - kept = mant[19:10], guard = mant[9], sticky = |mant[8:0].
  - Round up when guard & (sticky | kept[0]).
  - Carry out of kept (0x3FF+1) gives frac=0 and exp+=1.
  - Final classification, in priority order:
    - zero flag: out_data = {sign, 15'h0}.
    - exp>=31: out_data = {sign, 5'h1F, 10'h0} (infinity).
    - exp<=0: out_data = {sign, 15'h0}. No subnormal output.
    - Otherwise: out_data = {sign, exp[4:0], frac}.
  - Go to DONE with out_valid=1.
- DONE:
  - out_valid=1 and out_data stable until out_ready.
  - On out_valid&out_ready: out_valid=0 next cycle and return to IDLE. in_ready rises that same cycle.
  - No overlap: a new input cannot be accepted in the cycle the output is taken.
- Latency, counted from the accepting edge to out_valid high:
  - 3 cycles for an input already in [1,2).
  - 3 cycles for an input in [2,4); the right shift takes the NORM cycle.
  - 3+k cycles for k left shifts.
  - 2 cycles for a zero mantissa.
- Throughput: one result per latency+1 cycles when out_ready is held high.
- out_ready asserted while not in DONE is ignored.
- in_valid while in_ready=0 is ignored. The upstream must hold its data until it is accepted.

Decomposition:
- fp16_pkg holds:
  - FP16_BIAS=15, FP16_EXP_W=5, FP16_FRAC_W=10.
  - FP16_INF_MAG=15'h7C00.
  - typedef for the state enum {IDLE, NORM, ROUND, DONE}.
- Sub-module fp16_round_rne, combinational.
  - Inputs: kept[9:0], guard, sticky.
  - Outputs: frac[9:0], carry.
  - Reused later by the adder path.

Test Plan:
1. sign=0, exp=15, mant=0x100000, out_ready=1 -> out_data=0x3C00, out_valid exactly 3 cycles after accept, in_ready back high the next cycle.
2. sign=0, exp=15, mant=0x240000 (1.5*1.5) -> one right shift, out_data=0x4080. Also mant=0x1FFE00 (RNE tie, round carry) -> out_data=0x4000.
3. RNE ties:
   - mant=0x100200, exp=15 -> 0x3C00 (tie, round down to even).
   - mant=0x100600 -> 0x3C02 (tie, round up).
   - mant=0x100201 -> 0x3C01 (sticky forces up).
4. Range limits:
   - exp=30, mant=0x3FFFFF, sign=1 -> 0xFC00 (overflow).
   - exp=0, mant=0x100000, sign=1 -> 0x8000 (underflow flush).
   - mant=0 with any exp -> signed zero, latency 2.
5. mant=0x040000, exp=15 -> two left shifts, out_data=0x3400, latency 5. Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0 throughout.
6. Assert rst_n=0 during NORM of case 5 -> out_valid=0 and in_ready=1 immediately. After release, case 1 runs normally with no stale output.

Source files
------------

// File: rtl/fp16_pkg.sv
// ---------------------------------------------------------------------------
// fp16_pkg
// Shared constants and types for the half-precision arithmetic back ends.
//   FP16_*        : binary16 field widths, bias and special encodings
//   RAW_EXP_W     : width of the raw biased exponent sum from the front end
//   state_e       : control states of the normalise/round/pack sequencer
//   fp16_pack()   : assembles {sign, exponent, fraction} into a binary16 word
// ---------------------------------------------------------------------------
package fp16_pkg;

    localparam int FP16_BIAS    = 15;
    localparam int FP16_EXP_W   = 5;
    localparam int FP16_FRAC_W  = 10;
    // Largest biased exponent field; reserved for infinity/NaN.
    localparam int FP16_EXP_MAX = 2 * FP16_BIAS + 1;
    localparam logic [14:0] FP16_INF_MAG = 15'h7C00;

    localparam int RAW_EXP_W = 7;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_e;

    function automatic logic [15:0] fp16_pack(
        input logic                   sign,
        input logic [FP16_EXP_W-1:0]  exp,
        input logic [FP16_FRAC_W-1:0] frac
    );
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp16_norm_pack_if.sv
// ---------------------------------------------------------------------------
// fp16_norm_pack_if
// Valid/ready handshake bundle between the multiplier front end, the
// normalise/pack back end and its consumer.
//   in_*   : raw product (sign, biased exponent sum, mantissa) + handshake
//   out_*  : packed binary16 result + handshake
// Modports:
//   slave  : the back end (consumes in_*, produces out_*)
//   master : the environment (produces in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface fp16_norm_pack_if
    import fp16_pkg::*;
#(
    parameter int MANT_W = 22
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic [RAW_EXP_W-1:0] in_exp;
    logic [MANT_W-1:0]    in_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_data;

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_sign, in_exp, in_mant, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/fp16_round_rne.sv
// ---------------------------------------------------------------------------
// fp16_round_rne
// Combinational round-to-nearest-even of a 10-bit fraction.
//   kept_i   : fraction bits retained after normalisation
//   guard_i  : first bit below the kept LSB
//   sticky_i : OR of every bit below the guard bit
//   frac_o   : rounded fraction
//   carry_o  : rounding overflowed the fraction (kept was all ones)
// ---------------------------------------------------------------------------
module fp16_round_rne
    import fp16_pkg::*;
(
    input  logic [FP16_FRAC_W-1:0] kept_i,
    input  logic                   guard_i,
    input  logic                   sticky_i,
    output logic [FP16_FRAC_W-1:0] frac_o,
    output logic                   carry_o
);
    logic round_up;

    // Exact ties (guard set, nothing below) round toward an even LSB.
    assign round_up = guard_i & (sticky_i | kept_i[0]);

    assign {carry_o, frac_o} = {1'b0, kept_i} + {{FP16_FRAC_W{1'b0}}, round_up};

endmodule

// File: rtl/fp16_norm_pack.sv
// ---------------------------------------------------------------------------
// fp16_norm_pack
// Back end of the half-precision multiplier: normalises the raw mantissa
// product one bit per cycle, rounds to nearest even, saturates overflow to
// infinity, flushes underflow to signed zero and packs a binary16 word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; abandons any job in flight
//   bus   : slave side of fp16_norm_pack_if
//           in_mant is the product scaled by 2^-20 (normal range [1,4)),
//           in_exp the two's-complement biased exponent sum.
// ---------------------------------------------------------------------------
module fp16_norm_pack
    import fp16_pkg::*;
#(
    parameter int MANT_W = 22,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    fp16_norm_pack_if.slave   bus
);
    // Normalised layout: bit MANT_W-2 is the hidden one, then the kept
    // fraction, then the guard bit, then the sticky field.
    localparam int GUARD_BIT = MANT_W - 3 - FP16_FRAC_W;

    localparam logic signed [EXP_W-1:0] EXP_INF  = EXP_W'(FP16_EXP_MAX);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;

    state_e                   state_q;
    logic                     sign_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0]        mant_q;
    logic                     zero_q;
    logic                     out_valid_q;
    logic [15:0]              out_data_q;

    logic [FP16_FRAC_W-1:0]   frac_rnd;
    logic                     carry_rnd;
    logic signed [EXP_W-1:0]  exp_rnd;
    logic [15:0]              packed_d;

    fp16_round_rne u_round (
        .kept_i   (mant_q[GUARD_BIT+FP16_FRAC_W:GUARD_BIT+1]),
        .guard_i  (mant_q[GUARD_BIT]),
        .sticky_i (|mant_q[GUARD_BIT-1:0]),
        .frac_o   (frac_rnd),
        .carry_o  (carry_rnd)
    );

    // A rounding carry turns 1.111..1 into 10.000..0: fraction wraps to
    // zero (already true of frac_rnd) and the exponent steps up by one.
    assign exp_rnd = exp_q + $signed({{(EXP_W-1){1'b0}}, carry_rnd});

    // NOTE: every variable driven in always_comb gets a default before any
    // branch, so no path leaves it holding its old value and no latch is built.
    always_comb begin
        packed_d = '0;
        if (zero_q) begin
            packed_d = fp16_pack(sign_q, '0, '0);
        end else if (exp_rnd >= EXP_INF) begin
            packed_d = {sign_q, FP16_INF_MAG};
        end else if (exp_rnd <= EXP_ZERO) begin
            packed_d = fp16_pack(sign_q, '0, '0);
        end else begin
            packed_d = fp16_pack(sign_q, exp_rnd[FP16_EXP_W-1:0], frac_rnd);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q <= bus.in_sign;
                        exp_q  <= {{(EXP_W-RAW_EXP_W){bus.in_exp[RAW_EXP_W-1]}}, bus.in_exp};
                        mant_q <= bus.in_mant;
                        zero_q <= (bus.in_mant == '0);
                        // A zero product has nothing to normalise.
                        state_q <= (bus.in_mant == '0) ? ROUND : NORM;
                    end
                end

                NORM: begin
                    if (mant_q[MANT_W-1]) begin
                        // Product in [2,4): one right shift, keeping the lost
                        // bit alive in the sticky field.
                        mant_q  <= {1'b0, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                        exp_q   <= exp_q + EXP_W'(1);
                        state_q <= ROUND;
                    end else if (!mant_q[MANT_W-2]) begin
                        // Terminates: mant is nonzero, so the hidden bit is
                        // reached within MANT_W-2 shifts.
                        mant_q <= mant_q << 1;
                        exp_q  <= exp_q - EXP_W'(1);
                    end else begin
                        state_q <= ROUND;
                    end
                end

                ROUND: begin
                    out_data_q  <= packed_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fp16_norm_pack.sv
// ---------------------------------------------------------------------------
// tb_fp16_norm_pack
// Self-checking bench for fp16_norm_pack: directed vector table, output
// hold / back-pressure sequence, mid-job reset, and randomized operands
// compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_fp16_norm_pack;

    localparam int MANT_W = 22;
    localparam int CLK_P  = 10;

    logic clk = 1'b0;
    logic rst_n;

    always #(CLK_P/2) clk = ~clk;

    fp16_norm_pack_if #(.MANT_W(MANT_W)) bus ();

    fp16_norm_pack #(.MANT_W(MANT_W), .EXP_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        sign;
        logic [6:0]  exp;
        logic [21:0] mant;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: value = mant * 2^-20 * 2^(exp-15). Find the leading one,
    // round the significand to 11 bits with exact integer remainder, then
    // classify the resulting biased exponent.
    task automatic model(input logic s, input logic [6:0] e7, input logic [21:0] m,
                         output logic [15:0] d, output int lat);
        int     e;
        int     p;
        int     big_e;
        longint q;
        longint rem;
        longint half;
        e = $signed(e7);
        if (m == 0) begin
            d   = {s, 15'h0};
            lat = 2;
            return;
        end
        p = 21;
        while (m[p] == 1'b0) p--;
        big_e = e + p - 20;
        if (p > 10) begin
            q    = longint'(m) >> (p - 10);
            rem  = longint'(m) - (q << (p - 10));
            half = longint'(1) << (p - 11);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = longint'(m) << (10 - p);
        end
        if (q == 2048) begin
            q = 1024;
            big_e++;
        end
        if (big_e >= 31)     d = {s, 15'h7C00};
        else if (big_e <= 0) d = {s, 15'h0};
        else                 d = {s, 5'(big_e), 10'(q & 1023)};
        lat = (p >= 20) ? 3 : 3 + (20 - p);
    endtask

    // One transaction. lat counts rising edges from the accepting edge
    // (inclusive) up to the edge after which out_valid is seen high.
    task automatic do_op(input logic s, input logic [6:0] e, input logic [21:0] m,
                         input int hold, output logic [15:0] d, output int lat,
                         output time acc_t);
        int wait_c = 0;
        while (!bus.in_ready && wait_c < 200) begin
            @(posedge clk);
            #1;
            wait_c++;
        end
        if (!bus.in_ready) check("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_sign   = s;
        bus.in_exp    = e;
        bus.in_mant   = m;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        acc_t = $time;
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_valid) begin
            check("out_valid_timeout", 32'd0, 32'd1);
            d = 16'hxxxx;
            bus.out_ready = 1'b1;
            return;
        end
        d = bus.out_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_out_data",  32'(bus.out_data),  32'(d));
            check("hold_in_ready",  32'(bus.in_ready),  32'd0);
        end
        if (hold > 0) bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("taken_out_valid", 32'(bus.out_valid), 32'd0);
        check("taken_in_ready",  32'(bus.in_ready),  32'd1);
    endtask

    vec_t        vecs[$];
    logic [15:0] d;
    logic [15:0] md;
    int          lat;
    int          mlat;
    time         acc_t;
    time         prev_t;
    int          prev_lat;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        #12;
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_in_ready",  32'(bus.in_ready),  32'd1);
        check("reset_out_data",  32'(bus.out_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: expected values derived by hand from the rules.
        vecs.push_back('{1'b0, 7'd15, 22'h100000, 16'h3C00, 3});  // 1.0
        vecs.push_back('{1'b0, 7'd15, 22'h240000, 16'h4080, 3});  // 1.5*1.5
        vecs.push_back('{1'b0, 7'd15, 22'h1FFE00, 16'h4000, 3});  // tie, carry
        vecs.push_back('{1'b0, 7'd15, 22'h100200, 16'h3C00, 3});  // tie down
        vecs.push_back('{1'b0, 7'd15, 22'h100600, 16'h3C02, 3});  // tie up
        vecs.push_back('{1'b0, 7'd15, 22'h100201, 16'h3C01, 3});  // sticky
        vecs.push_back('{1'b1, 7'd30, 22'h3FFFFF, 16'hFC00, 3});  // overflow
        vecs.push_back('{1'b1, 7'd0,  22'h100000, 16'h8000, 3});  // underflow
        vecs.push_back('{1'b0, 7'd40, 22'h000000, 16'h0000, 2});  // zero
        vecs.push_back('{1'b1, 7'h71, 22'h000000, 16'h8000, 2});  // -0, exp=-15
        vecs.push_back('{1'b0, 7'd15, 22'h040000, 16'h3400, 5});  // 2 left shifts
        vecs.push_back('{1'b0, 7'd31, 22'h100000, 16'h7C00, 3});  // exp 31 -> inf
        vecs.push_back('{1'b0, 7'd1,  22'h100000, 16'h0400, 3});  // min normal
        vecs.push_back('{1'b0, 7'd30, 22'h1FFFFF, 16'h7C00, 3});  // carry -> inf
        vecs.push_back('{1'b0, 7'd45, 22'h000001, 16'h6400, 23}); // 20 shifts

        foreach (vecs[i]) begin
            do_op(vecs[i].sign, vecs[i].exp, vecs[i].mant, 0, d, lat, acc_t);
            check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'(vecs[i].exp_lat));
        end

        // Back-pressure: output held for 10 cycles with out_ready low.
        do_op(1'b0, 7'd15, 22'h040000, 10, d, lat, acc_t);
        check("hold_data", 32'(d), 32'h3400);
        check("hold_lat",  32'(lat), 32'd5);

        // Reset during NORM of the left-shift case.
        @(negedge clk);
        bus.in_sign   = 1'b0;
        bus.in_exp    = 7'd15;
        bus.in_mant   = 22'h040000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst_out_data",  32'(bus.out_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_stale", 32'(bus.out_valid), 32'd0);
        end
        do_op(1'b0, 7'd15, 22'h100000, 0, d, lat, acc_t);
        check("post_rst_data", 32'(d), 32'h3C00);
        check("post_rst_lat",  32'(lat), 32'd3);

        // Randomized operands against the reference model, back to back;
        // also checks the accept-to-accept period equals latency + 1.
        for (int i = 0; i < 300; i++) begin
            logic        s;
            logic [6:0]  e;
            logic [21:0] m;
            s = 1'($urandom);
            e = 7'($urandom_range(0, 60) - 15);
            case ($urandom_range(0, 7))
                0:       m = '0;
                1:       m = 22'($urandom) >> $urandom_range(0, 21);
                2:       m = {2'b01, 10'($urandom), 1'b1, 9'h0};
                3:       m = {1'b1, 9'($urandom), 1'b1, 1'b0, 10'h0};
                default: m = 22'($urandom);
            endcase
            model(s, e, m, md, mlat);
            do_op(s, e, m, 0, d, lat, acc_t);
            check($sformatf("rand%0d_data m=%h e=%0d", i, m, $signed(e)), 32'(d), 32'(md));
            check($sformatf("rand%0d_lat", i), 32'(lat), 32'(mlat));
            if (i > 0)
                check($sformatf("rand%0d_period", i), 32'(acc_t - prev_t),
                      32'((prev_lat + 1) * CLK_P));
            prev_t   = acc_t;
            prev_lat = lat;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
